// File: rtl/mem_loader_pkg.sv
// Shared constants for the mem_loader block: FSM state encoding, transfer modes, widths.
package mem_loader_pkg;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RDREQ = 3'd2;
    localparam logic [2:0] ST_RDOUT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_DUMP = 1'b1;

endpackage

// File: rtl/mem_loader_ctr.sv
// Address/count registers for mem_loader: load on start, step per transferred byte.
module mem_loader_ctr #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [ADDR_BITS-1:0] base,
    input  logic [ADDR_BITS:0]   len,
    output logic [ADDR_BITS-1:0] addr,
    output logic [ADDR_BITS:0]   count,
    output logic                 last,
    output logic                 zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr  <= '0;
            count <= '0;
        end else if (load) begin
            addr  <= base;
            count <= len;
        end else if (step) begin
            // addr wraps naturally at the top of the address space
            addr  <= addr + ADDR_BITS'(1);
            count <= count - (ADDR_BITS + 1)'(1);
        end
    end

    assign last = (count == (ADDR_BITS + 1)'(1));
    assign zero = (count == '0);

endmodule

// File: rtl/mem_loader.sv
// Stream <-> memory block transfer engine (load: stream to memory, dump: memory to stream).
// Optional running checksum enabled by defining MEM_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting stream bytes, one memory write per handshake
// RDREQ | memory read issued for current addr
// RDOUT | read byte presented on out stream until accepted
// DONE  | one-cycle completion pulse
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_BITS-1:0] base,
    input  logic [ADDR_BITS:0]   len,
    output logic                 busy,
    output logic                 done,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 mem_en,
    output logic                 mem_write,
    output logic [ADDR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic [WIDTH-1:0]     checksum
);

    logic [2:0]           state;
    logic [ADDR_BITS-1:0] addr;
    logic [ADDR_BITS:0]   count;
    logic                 last;
    logic                 zero;
    logic                 ctr_load;
    logic                 ctr_step;
    logic                 in_hs;
    logic                 out_hs;

    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign ctr_load = (state == ST_IDLE) && start && (len != '0);
    assign ctr_step = ((state == ST_LOAD) && in_hs) || ((state == ST_RDOUT) && out_hs);

    // After the final load handshake the FSM lingers one cycle in LOAD so the
    // last write completes before DONE; in_ready is held off during that cycle.
    assign in_ready = (state == ST_LOAD) && !zero;
    assign busy     = (state == ST_LOAD) || (state == ST_RDREQ) || (state == ST_RDOUT);
    assign done     = (state == ST_DONE);

    mem_loader_ctr #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (ctr_load),
        .step  (ctr_step),
        .base  (base),
        .len   (len),
        .addr  (addr),
        .count (count),
        .last  (last),
        .zero  (zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            state <= ST_DONE;
                        end else if (mode == MODE_DUMP) begin
                            state   <= ST_RDREQ;
                            mem_en  <= 1'b1;
                            mem_adr <= base;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (zero) begin
                        state <= ST_DONE;
                    end else if (in_hs) begin
                        mem_en    <= 1'b1;
                        mem_write <= 1'b1;
                        mem_adr   <= addr;
                        mem_wdata <= in_data;
                    end
                end
                ST_RDREQ: begin
                    out_data  <= mem_rdata;
                    out_valid <= 1'b1;
                    state     <= ST_RDOUT;
                end
                ST_RDOUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last) begin
                            state <= ST_DONE;
                        end else begin
                            state   <= ST_RDREQ;
                            mem_en  <= 1'b1;
                            mem_adr <= addr + ADDR_BITS'(1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if ((state == ST_IDLE) && start) begin
            checksum <= '0;
        end else if ((state == ST_LOAD) && in_hs) begin
            checksum <= checksum + in_data;
        end else if (state == ST_RDREQ) begin
            checksum <= checksum + mem_rdata;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: queued expected writes/reads checked by a negedge monitor.
module tb_mem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, mode;
    logic [7:0] base;
    logic [8:0] len;
    logic       busy, done;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_ready;
    logic       mem_en, mem_write;
    logic [7:0] mem_adr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] checksum;

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    mem_loader dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .base(base), .len(len),
        .busy(busy), .done(done), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mem_en(mem_en), .mem_write(mem_write), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // memory behaviour: sample address/strobes on negedge
    logic [7:0] bus_mem [0:255];
    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_write) bus_mem[mem_adr] <= mem_wdata;
            else           mem_rdata <= bus_mem[mem_adr];
        end
    end

    // reference model and scoreboard
    logic [7:0]  ref_mem [0:255];
    logic [7:0]  stim    [0:255];
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [7:0]  exp_ck;
    int wr_cnt = 0, en_cnt = 0, done_cnt = 0;

    logic [15:0] wexp;
    logic [7:0]  rexp, held;
    logic        held_v = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_en) en_cnt++;
            if (mem_en && mem_write) begin
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_write: got adr %0h data %0h expected no write", mem_adr, mem_wdata);
                end else begin
                    wexp = wr_q.pop_front();
                    chk("mem_write", {mem_adr, mem_wdata}, wexp);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_mem_en", mem_en, 0);
            end
            if (out_valid) begin
                if (held_v) chk("out_hold", out_data, held);
                if (out_ready) begin
                    held_v = 1'b0;
                    if (rd_q.size() == 0) begin
                        checks++;
                        $display("FAIL spurious_out: got %0h expected no output", out_data);
                    end else begin
                        rexp = rd_q.pop_front();
                        chk("out_data", out_data, rexp);
                    end
                end else begin
                    held   = out_data;
                    held_v = 1'b1;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic m, input logic [7:0] b, input logic [8:0] l);
        start = 1'b1; mode = m; base = b; len = l;
        cyc(1);
        start = 1'b0;
        exp_ck = 8'h00;
    endtask

    task automatic finish_transfer(input int d0, input int budget, input string name);
        for (int i = 0; i < budget && done_cnt == d0; i++) cyc(1);
        cyc(2);
        chk({name, "_done_once"}, done_cnt - d0, 1);
        chk({name, "_idle"}, busy, 0);
        chk({name, "_checksum"}, checksum, CK_EN ? exp_ck : 8'h00);
        chk({name, "_wr_q_empty"}, wr_q.size(), 0);
        chk({name, "_rd_q_empty"}, rd_q.size(), 0);
    endtask

    task automatic send_byte(input logic [7:0] a, input logic [7:0] d, output bit ok);
        logic hs;
        ok = 1'b0;
        in_valid = 1'b0;
        cyc($urandom_range(0, 2));
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 40; t++) begin
            hs = in_ready;
            cyc(1);
            if (hs) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL in_handshake: got no in_ready expected accept at adr %0h", a);
        end else begin
            wr_q.push_back({a, d});
            ref_mem[a] = d;
            exp_ck += d;
        end
    endtask

    task automatic do_load(input logic [7:0] b, input int l, input string name);
        int d0;
        bit ok;
        d0 = done_cnt;
        issue_start(1'b0, b, 9'(l));
        for (int i = 0; i < l; i++) begin
            send_byte(b + 8'(i), stim[i], ok);
            if (!ok) break;
        end
        finish_transfer(d0, 20, name);
    endtask

    task automatic do_dump(input logic [7:0] b, input int l, input bit poke, input string name);
        int d0, w0;
        d0 = done_cnt;
        w0 = wr_cnt;
        issue_start(1'b1, b, 9'(l));
        for (int i = 0; i < l; i++) begin
            rd_q.push_back(ref_mem[b + 8'(i)]);
            exp_ck += ref_mem[b + 8'(i)];
        end
        for (int i = 0; i < l * 10 + 20 && done_cnt == d0; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (poke && i == 2) begin
                start = 1'b1; mode = 1'b0; base = 8'h77; len = 9'd4;
            end else begin
                start = 1'b0;
            end
            cyc(1);
        end
        start = 1'b0;
        out_ready = 1'b0;
        finish_transfer(d0, 4, name);
        chk({name, "_no_writes"}, wr_cnt - w0, 0);
    endtask

    int d0, w0, e0;
    bit ok;
    logic [7:0] rb;
    int rl;

    initial begin
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        reset = 1'b1; start = 1'b0; mode = 1'b0; base = 8'h00; len = 9'd0;
        in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0; exp_ck = 8'h00;
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_adr", mem_adr, 8'h00);
        chk("rst_checksum", checksum, 8'h00);
        reset = 1'b0;
        cyc(2);

        stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC;
        do_load(8'h10, 3, "load_basic");
        chk("load_checksum_const", checksum, CK_EN ? 32'h31 : 32'h00);
        chk("mem_10", bus_mem[8'h10], 8'hAA);
        chk("mem_11", bus_mem[8'h11], 8'hBB);
        chk("mem_12", bus_mem[8'h12], 8'hCC);
        do_dump(8'h10, 3, 1'b0, "dump_basic");

        stim[0] = 8'h01; stim[1] = 8'h02;
        do_load(8'hFF, 2, "load_wrap");
        chk("mem_FF", bus_mem[8'hFF], 8'h01);
        chk("mem_00", bus_mem[8'h00], 8'h02);
        do_dump(8'hFF, 2, 1'b0, "dump_wrap");

        // zero length: done on the cycle after start is sampled, no memory access
        e0 = en_cnt;
        d0 = done_cnt;
        issue_start(1'b0, 8'h40, 9'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        cyc(1);
        chk("zero_done_drop", done, 0);
        chk("zero_done_count", done_cnt - d0, 1);
        chk("zero_no_mem_en", en_cnt - e0, 0);
        chk("zero_checksum", checksum, 8'h00);

        // reset after the second byte of a five-byte load has been written
        d0 = done_cnt;
        w0 = wr_cnt;
        stim[0] = 8'h5A; stim[1] = 8'hA5;
        issue_start(1'b0, 8'h20, 9'd5);
        send_byte(8'h20, stim[0], ok);
        send_byte(8'h21, stim[1], ok);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_mem_en", mem_en, 0);
        chk("abort_mem_write", mem_write, 0);
        chk("abort_mem_adr", mem_adr, 8'h00);
        chk("abort_mem_wdata", mem_wdata, 8'h00);
        chk("abort_out_data", out_data, 8'h00);
        chk("abort_checksum", checksum, 8'h00);
        cyc(3);
        reset = 1'b0;
        cyc(5);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_writes", wr_cnt - w0, 2);
        chk("abort_wr_q_empty", wr_q.size(), 0);

        // second start during a dump must be ignored
        do_dump(8'h0E, 6, 1'b1, "dump_busy_start");

        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom_range(0, 255));
            rl = $urandom_range(1, 24);
            for (int i = 0; i < rl; i++) stim[i] = 8'($urandom_range(0, 255));
            do_load(rb, rl, "load_rand");
            do_dump(rb - 8'($urandom_range(0, 3)), rl + $urandom_range(0, 4), 1'b0, "dump_rand");
        end

        rb = 8'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) stim[i] = 8'($urandom_range(0, 255));
        do_load(rb, 256, "load_full");
        do_dump(rb + 8'h80, 256, 1'b0, "dump_full");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
